// File: rtl/fpu_issue_ctrl_if.sv
// Bundle of the command, FPU-drive, FPU-result and result-buffer signals
// around the FPU issue controller.
interface fpu_issue_ctrl_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [1:0]  cmd_rmode;
   logic [31:0] cmd_opa;
   logic [31:0] cmd_opb;

   logic [2:0]  fpu_op;
   logic [1:0]  rmode;
   logic [31:0] opa;
   logic [31:0] opb;

   logic [31:0] fpu_out;
   logic        fpu_inf;
   logic        fpu_snan;
   logic        fpu_qnan;
   logic        fpu_ine;
   logic        fpu_overflow;
   logic        fpu_underflow;
   logic        fpu_zero;
   logic        fpu_div_by_zero;

   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic [7:0]  res_flags;
   logic [3:0]  res_tag;

   modport slave (
      input  cmd_valid, cmd_op, cmd_rmode, cmd_opa, cmd_opb,
      output cmd_ready,
      output fpu_op, rmode, opa, opb,
      input  fpu_out, fpu_inf, fpu_snan, fpu_qnan, fpu_ine,
      input  fpu_overflow, fpu_underflow, fpu_zero, fpu_div_by_zero,
      output res_valid, res_data, res_flags, res_tag,
      input  res_ready
   );

   modport master (
      output cmd_valid, cmd_op, cmd_rmode, cmd_opa, cmd_opb,
      input  cmd_ready,
      input  fpu_op, rmode, opa, opb,
      output fpu_out, fpu_inf, fpu_snan, fpu_qnan, fpu_ine,
      output fpu_overflow, fpu_underflow, fpu_zero, fpu_div_by_zero,
      input  res_valid, res_data, res_flags, res_tag,
      output res_ready
   );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Issues commands to a fixed-latency FPU, tracks them with tagged in-flight
// markers and buffers the results in order for the consumer.
module fpu_issue_ctrl #(
   parameter int LATENCY = 4,
   parameter int DEPTH   = 4
) (
   input logic           clk,
   input logic           rst,
   fpu_issue_ctrl_if.slave bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [31:0] data;
      logic [7:0]  flags;
      logic [3:0]  tag;
   } entry_t;

   logic             cmd_ready_q, cmd_ready_d;
   logic [CNT_W-1:0] occ_q, occ_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [3:0]       tag_q, tag_d;
   logic [LATENCY:0] stage_v_q, stage_v_d;
   logic [3:0]       stage_tag_q [LATENCY+1];
   logic [3:0]       stage_tag_d [LATENCY+1];
   logic [2:0]       fpu_op_q, fpu_op_d;
   logic [1:0]       rmode_q, rmode_d;
   logic [31:0]      opa_q, opa_d;
   logic [31:0]      opb_q, opb_d;
   entry_t           mem_q [DEPTH];

   logic   accept;
   logic   pop;
   logic   capture;
   logic   res_valid;
   entry_t cap_entry;
   entry_t head;

   // Stage 0 of the marker chain lines up with the operand register, so a
   // marker reaches the last stage just as the FPU result becomes valid.
   always_comb begin
      accept    = bus.cmd_valid && cmd_ready_q;
      res_valid = (cnt_q != '0);
      pop       = res_valid && bus.res_ready;
      capture   = stage_v_q[LATENCY];

      cap_entry.data  = bus.fpu_out;
      cap_entry.flags = {bus.fpu_div_by_zero, bus.fpu_zero, bus.fpu_underflow,
                         bus.fpu_overflow, bus.fpu_ine, bus.fpu_qnan,
                         bus.fpu_snan, bus.fpu_inf};
      cap_entry.tag   = stage_tag_q[LATENCY];

      stage_v_d      = {stage_v_q[LATENCY-1:0], accept};
      stage_tag_d[0] = tag_q;
      for (int i = 1; i <= LATENCY; i++) begin
         stage_tag_d[i] = stage_tag_q[i-1];
      end

      tag_d    = accept ? tag_q + 4'd1 : tag_q;
      fpu_op_d = accept ? bus.cmd_op    : fpu_op_q;
      rmode_d  = accept ? bus.cmd_rmode : rmode_q;
      opa_d    = accept ? bus.cmd_opa   : opa_q;
      opb_d    = accept ? bus.cmd_opb   : opb_q;

      occ_d    = occ_q + CNT_W'(accept) - CNT_W'(pop);
      cnt_d    = cnt_q + CNT_W'(capture) - CNT_W'(pop);
      wr_ptr_d = capture ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

      // Occupancy counts markers still in flight, so a capture always finds room.
      cmd_ready_d = (occ_d < CNT_W'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_ready_q <= 1'b0;
         occ_q       <= '0;
         cnt_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         tag_q       <= '0;
         stage_v_q   <= '0;
         stage_tag_q <= '{default: '0};
         fpu_op_q    <= '0;
         rmode_q     <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
      end else begin
         cmd_ready_q <= cmd_ready_d;
         occ_q       <= occ_d;
         cnt_q       <= cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         tag_q       <= tag_d;
         stage_v_q   <= stage_v_d;
         stage_tag_q <= stage_tag_d;
         fpu_op_q    <= fpu_op_d;
         rmode_q     <= rmode_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && capture) begin
         mem_q[wr_ptr_q] <= cap_entry;
      end
   end

   assign head = mem_q[rd_ptr_q];

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.fpu_op    = fpu_op_q;
   assign bus.rmode     = rmode_q;
   assign bus.opa       = opa_q;
   assign bus.opb       = opb_q;
   assign bus.res_valid = res_valid;
   // The buffer storage is not reset; an empty buffer presents zeros instead.
   assign bus.res_data  = res_valid ? head.data  : '0;
   assign bus.res_flags = res_valid ? head.flags : '0;
   assign bus.res_tag   = res_valid ? head.tag   : '0;

   capture_never_full: assert property (@(posedge clk) disable iff (rst)
      capture |-> (cnt_q < CNT_W'(DEPTH)));

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: a fake fixed-latency FPU, a queue-based reference
// model, vector table, hand sequences, random traffic and a streaming instance.
module tb_fpu_issue_ctrl;

   localparam int LAT   = 4;
   localparam int DEP   = 4;
   localparam int DEP_S = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fpu_issue_ctrl_if bus ();
   fpu_issue_ctrl_if sbus ();

   fpu_issue_ctrl #(.LATENCY(LAT), .DEPTH(DEP)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   fpu_issue_ctrl #(.LATENCY(LAT), .DEPTH(DEP_S)) u_stream (
      .clk (clk),
      .rst (rst),
      .bus (sbus)
   );

   always #5 clk = ~clk;

   function automatic real to_real(input logic [31:0] a);
      logic [10:0] e;
      if (a[30:0] == 31'd0) return 0.0;
      e = {3'b000, a[30:23]} + 11'd896;
      return $bitstoreal({a[31], e, a[22:0], 29'd0});
   endfunction

   function automatic logic [31:0] to_single(input real r);
      logic [63:0] d;
      logic [10:0] e;
      d = $realtobits(r);
      if (d[62:0] == 63'd0) return 32'd0;
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   // Stand-in FPU behaviour: {flags, result} for exact small operands.
   function automatic logic [39:0] fpu_func(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      real         ra, rb, rr;
      logic [31:0] r;
      ra = to_real(a);
      rb = to_real(b);
      rr = 0.0;
      if (op > 3'd3) return {8'h00, a};
      if (op == 3'd3 && rb == 0.0) return {8'h81, a[31] ^ b[31], 8'hFF, 23'd0};
      case (op)
         3'd0:    rr = ra + rb;
         3'd1:    rr = ra - rb;
         3'd2:    rr = ra * rb;
         default: rr = ra / rb;
      endcase
      r = to_single(rr);
      return {(r[30:0] == 31'd0) ? 8'h40 : 8'h00, r};
   endfunction

   logic [39:0] pipe  [LAT];
   logic [39:0] spipe [LAT];

   always @(posedge clk) begin
      pipe[0]  <= fpu_func(bus.fpu_op, bus.opa, bus.opb);
      spipe[0] <= fpu_func(sbus.fpu_op, sbus.opa, sbus.opb);
      for (int k = 1; k < LAT; k++) begin
         pipe[k]  <= pipe[k-1];
         spipe[k] <= spipe[k-1];
      end
   end

   assign bus.fpu_out = pipe[LAT-1][31:0];
   assign {bus.fpu_div_by_zero, bus.fpu_zero, bus.fpu_underflow, bus.fpu_overflow,
           bus.fpu_ine, bus.fpu_qnan, bus.fpu_snan, bus.fpu_inf} = pipe[LAT-1][39:32];
   assign sbus.fpu_out = spipe[LAT-1][31:0];
   assign {sbus.fpu_div_by_zero, sbus.fpu_zero, sbus.fpu_underflow, sbus.fpu_overflow,
           sbus.fpu_ine, sbus.fpu_qnan, sbus.fpu_snan, sbus.fpu_inf} = spipe[LAT-1][39:32];

   typedef struct {
      logic [31:0] data;
      logic [7:0]  flags;
      logic [3:0]  tag;
      int          due;
   } exp_t;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_data;
      logic [7:0]  exp_flags;
   } vec_t;

   exp_t        mq[$];
   logic [3:0]  popped_tags[$];
   int          cyc = 0;
   logic [3:0]  m_tag = 4'd0;
   bit          m_rdy = 1'b0;
   bit          m_known = 1'b0;
   logic [2:0]  m_op = 3'd0;
   logic [1:0]  m_rm = 2'd0;
   logic [31:0] m_a = 32'd0;
   logic [31:0] m_b = 32'd0;
   int          n_checks = 0;
   int          n_pass = 0;
   int          n_acc = 0;
   bit          dut_acc = 1'b0;
   logic [31:0] vals [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F000000,
                             32'h3FC00000, 32'hC0000000, 32'h40800000, 32'h00000000};

   function automatic bit m_valid();
      return (mq.size() > 0) && (mq[0].due <= cyc);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic checkOutput();
      if (m_known) begin
         check("cmd_ready", 32'(bus.cmd_ready), 32'(m_rdy));
         check("res_valid", 32'(bus.res_valid), 32'(m_valid()));
         check("fpu_op", 32'(bus.fpu_op), 32'(m_op));
         check("rmode", 32'(bus.rmode), 32'(m_rm));
         check("opa", bus.opa, m_a);
         check("opb", bus.opb, m_b);
         if (m_valid()) begin
            check("res_data", bus.res_data, mq[0].data);
            check("res_flags", 32'(bus.res_flags), 32'(mq[0].flags));
            check("res_tag", 32'(bus.res_tag), 32'(mq[0].tag));
         end
      end
   endtask

   task automatic modelEdge(input bit v, input logic [2:0] op, input logic [1:0] rm,
                            input logic [31:0] a, input logic [31:0] b, input bit r);
      bit          pv;
      logic [39:0] f;
      if (rst) begin
         mq.delete();
         m_tag   = 4'd0;
         m_rdy   = 1'b0;
         m_known = 1'b1;
         {m_op, m_rm, m_a, m_b} = '0;
         cyc++;
      end else begin
         pv = m_valid();
         cyc++;
         if (pv && r) void'(mq.pop_front());
         if (v && m_rdy) begin
            f = fpu_func(op, a, b);
            mq.push_back('{data: f[31:0], flags: f[39:32], tag: m_tag, due: cyc + LAT + 1});
            m_tag++;
            m_op = op;
            m_rm = rm;
            m_a  = a;
            m_b  = b;
         end
         m_rdy = (mq.size() < DEP);
      end
   endtask

   task automatic applyStimulus(input bit v, input logic [2:0] op, input logic [1:0] rm,
                                input logic [31:0] a, input logic [31:0] b, input bit r);
      checkOutput();
      bus.cmd_valid = v;
      bus.cmd_op    = op;
      bus.cmd_rmode = rm;
      bus.cmd_opa   = a;
      bus.cmd_opb   = b;
      bus.res_ready = r;
      dut_acc = v && bus.cmd_ready;
      if (dut_acc) n_acc++;
      if (bus.res_valid && r) popped_tags.push_back(bus.res_tag);
      @(posedge clk);
      modelEdge(v, op, rm, a, b, r);
      #1;
   endtask

   task automatic idle(input bit r);
      applyStimulus(1'b0, 3'd0, 2'd0, 32'd0, 32'd0, r);
   endtask

   task automatic doReset();
      rst = 1'b1;
      idle(1'b0);
      check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check("rst_res_valid", 32'(bus.res_valid), 32'd0);
      check("rst_res_data", bus.res_data, 32'd0);
      check("rst_res_flags", 32'(bus.res_flags), 32'd0);
      check("rst_res_tag", 32'(bus.res_tag), 32'd0);
      check("rst_opa", bus.opa, 32'd0);
      check("rst_opb", bus.opb, 32'd0);
      idle(1'b0);
      rst = 1'b0;
      idle(1'b0);
   endtask

   task automatic waitResult(input string name, output int lat);
      lat = 0;
      while (!bus.res_valid && lat < 12) begin
         idle(1'b0);
         lat++;
      end
      check({name, "_latency"}, 32'(lat), 32'(LAT + 1));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t        vecs [7];
      int          lat;
      int          sent;
      int          guard;
      logic [31:0] sexp [20];
      logic [39:0] f;

      bus.cmd_valid  = 1'b0; bus.cmd_op  = 3'd0; bus.cmd_rmode  = 2'd0;
      bus.cmd_opa    = 32'd0; bus.cmd_opb = 32'd0; bus.res_ready = 1'b0;
      sbus.cmd_valid = 1'b0; sbus.cmd_op = 3'd0; sbus.cmd_rmode = 2'd0;
      sbus.cmd_opa   = 32'd0; sbus.cmd_opb = 32'd0; sbus.res_ready = 1'b0;

      vecs[0] = '{3'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 8'h00};
      vecs[1] = '{3'd3, 32'h3F800000, 32'h00000000, 32'h7F800000, 8'h81};
      vecs[2] = '{3'd1, 32'h40400000, 32'h40400000, 32'h00000000, 8'h40};
      vecs[3] = '{3'd2, 32'h40000000, 32'h40400000, 32'h40C00000, 8'h00};
      vecs[4] = '{3'd3, 32'h40400000, 32'hC0000000, 32'hBFC00000, 8'h00};
      vecs[5] = '{3'd5, 32'h12345678, 32'h0BADF00D, 32'h12345678, 8'h00};
      vecs[6] = '{3'd3, 32'hBF800000, 32'h00000000, 32'hFF800000, 8'h81};

      doReset();
      for (int k = 0; k < 7; k++) begin
         applyStimulus(1'b1, vecs[k].op, 2'(k), vecs[k].a, vecs[k].b, 1'b0);
         waitResult("vec", lat);
         check("vec_data", bus.res_data, vecs[k].exp_data);
         check("vec_flags", 32'(bus.res_flags), 32'(vecs[k].exp_flags));
         check("vec_tag", 32'(bus.res_tag), 32'(k));
         idle(1'b1);
      end

      // Backpressure: only DEPTH commands get in while nothing drains.
      doReset();
      n_acc = 0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 3'(i % 3), 2'd0, vals[i], vals[i + 1], 1'b0);
      end
      check("bp_accepted", 32'(n_acc), 32'd4);
      check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      popped_tags.delete();
      sent  = 4;
      guard = 0;
      while (popped_tags.size() < 6 && guard < 40) begin
         applyStimulus(sent < 6, 3'(sent % 3), 2'd1, vals[sent], vals[sent + 1], 1'b1);
         if (dut_acc) sent++;
         guard++;
      end
      check("bp_total_accepted", 32'(n_acc), 32'd6);
      check("bp_results", 32'(popped_tags.size()), 32'd6);
      for (int i = 0; i < popped_tags.size(); i++) check("bp_order", 32'(popped_tags[i]), 32'(i));

      // Tag wrap over 17 accepts.
      doReset();
      n_acc = 0;
      popped_tags.delete();
      guard = 0;
      while (popped_tags.size() < 17 && guard < 200) begin
         applyStimulus(n_acc < 17, 3'd0, 2'd0, vals[guard % 8], vals[(guard + 1) % 8], 1'b1);
         guard++;
      end
      check("wrap_results", 32'(popped_tags.size()), 32'd17);
      for (int i = 0; i < popped_tags.size(); i++) check("wrap_tag", 32'(popped_tags[i]), 32'(i % 16));

      // Reset while two results are still in flight.
      doReset();
      applyStimulus(1'b1, 3'd0, 2'd0, vals[0], vals[1], 1'b1);
      applyStimulus(1'b1, 3'd2, 2'd0, vals[1], vals[2], 1'b1);
      idle(1'b1);
      idle(1'b1);
      doReset();
      for (int i = 0; i < 10; i++) begin
         idle(1'b1);
         check("mid_rst_no_valid", 32'(bus.res_valid), 32'd0);
      end
      applyStimulus(1'b1, 3'd0, 2'd0, vals[2], vals[3], 1'b0);
      waitResult("mid_rst", lat);
      check("mid_rst_tag", 32'(bus.res_tag), 32'd0);
      check("mid_rst_data", bus.res_data, 32'h40600000);
      idle(1'b1);

      // Random traffic against the reference model, with occasional resets.
      doReset();
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         applyStimulus(($urandom % 4) != 0, 3'($urandom_range(0, 7)), 2'($urandom),
                       vals[$urandom % 8], vals[$urandom % 8], ($urandom % 3) != 0);
         rst = 1'b0;
      end
      idle(1'b1);

      // Streaming on the deeper instance: one command and one result per edge.
      doReset();
      for (int i = 0; i < 20; i++) begin
         f = fpu_func(3'(i % 3), vals[i % 8], vals[(i + 3) % 8]);
         sexp[i] = f[31:0];
      end
      for (int k = 0; k < 30; k++) begin
         if (k < 20) check("stream_cmd_ready", 32'(sbus.cmd_ready), 32'd1);
         check("stream_valid", 32'(sbus.res_valid), (k >= 6 && k < 26) ? 32'd1 : 32'd0);
         if (k >= 6 && k < 26) begin
            check("stream_tag", 32'(sbus.res_tag), 32'((k - 6) % 16));
            check("stream_data", sbus.res_data, sexp[k - 6]);
         end
         sbus.cmd_valid = (k < 20);
         sbus.cmd_op    = 3'(k % 3);
         sbus.cmd_opa   = vals[k % 8];
         sbus.cmd_opb   = vals[(k + 3) % 8];
         sbus.res_ready = 1'b1;
         @(posedge clk);
         #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 Parameter LATENCY, default 4: clk edges from operand-register update to a valid fpu_out, range 1..8.
REQ-002 Parameter DEPTH, default 4: result buffer entries, power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  command accepted at the edge where cmd_valid && cmd_ready.
REQ-007 cmd_op  input  3  FPU opcode (0 add, 1 sub, 2 mul, 3 div; other values passed through).
REQ-008 cmd_rmode  input  2  rounding mode.
REQ-009 cmd_opa, cmd_opb  input  32  IEEE-754 single operands.
REQ-010 fpu_op  output  3; rmode  output  2; opa, opb  output  32  registered drive to the FPU.
REQ-011 fpu_out  input  32  FPU result.
REQ-012 fpu_inf, fpu_snan, fpu_qnan, fpu_ine, fpu_overflow, fpu_underflow, fpu_zero, fpu_div_by_zero  input  1 each  FPU status flags.
REQ-013 res_valid  output  1  result buffer non-empty.
REQ-014 res_ready  input  1  result consumed at the edge where res_valid && res_ready.
REQ-015 res_data  output  32  head result value.
REQ-016 res_flags  output  8  {div_by_zero, zero, underflow, overflow, ine, qnan, snan, inf} of the head result.
REQ-017 res_tag  output  4  tag of the head result.

Function
REQ-018 On accept, fpu_op/rmode/opa/opb SHALL load the command at that edge and hold until the next accept.
REQ-019 Each accept SHALL insert a marker, carrying the current tag, into a LATENCY-stage in-flight shift register that advances every edge.
REQ-020 When a marker leaves the last stage, the same edge SHALL write fpu_out, the 8 flags and the marker's tag into the result FIFO.
REQ-021 Issue-to-res_valid latency SHALL be exactly LATENCY+1 edges when the FIFO is empty.
REQ-022 A tag counter (4 bits) SHALL start at 0, increment by 1 per accept and wrap 15 -> 0.
REQ-023 occupancy = in-flight marker count + FIFO count; cmd_ready SHALL be 1 iff occupancy < DEPTH, so a capture never finds the FIFO full.
REQ-024 Simultaneous accept and pop SHALL leave occupancy unchanged; simultaneous capture and pop SHALL keep the FIFO count unchanged.
REQ-025 Results SHALL emerge in issue order; res_data/res_flags/res_tag SHALL be stable while res_valid && !res_ready.
REQ-026 Back-to-back accepts on consecutive edges SHALL be supported, one per edge.
REQ-027 res_ready with the FIFO empty SHALL have no effect.
REQ-028 No FIFO entry SHALL ever be overwritten or lost; a capture into a full FIFO is a design error, flagged by an assertion.

Reset
REQ-029 While rst is high at an edge, the block SHALL clear the in-flight register, FIFO pointers and count, and the tag counter.
REQ-030 The same reset edge SHALL drive fpu_op, rmode, opa and opb to 0, and res_data, res_flags and res_tag to 0.
REQ-031 During reset, res_valid=0 and cmd_ready=0; cmd_ready SHALL rise on the first edge after rst falls.
REQ-032 Reset mid-operation SHALL discard all in-flight and buffered results; no result from before reset SHALL appear afterwards.

Verification
REQ-033 Add: op=0, opa=0x3F800000, opb=0x40000000, res_ready=1 -> res_valid high exactly 5 edges after accept, res_data=0x40400000, res_flags=0, res_tag=0.
REQ-034 Div by zero: op=3, opa=0x3F800000, opb=0 -> res_data=0x7F800000, res_flags bits 7 and 0 set.
REQ-035 Backpressure: res_ready=0, 6 commands offered back-to-back -> 4 accepted, cmd_ready=0 after the 4th accept; then res_ready=1 -> 4 results in order with tags 0..3, 5th and 6th commands accepted.
REQ-036 Tag wrap: 17 sequential accepts -> tags 0..15, then 0.
REQ-037 Reset 2 edges after 2 accepts -> no res_valid for 10 edges after reset; next accept gets tag 0.
REQ-038 Streaming: cmd_valid=1 and res_ready=1 for 20 edges -> cmd_ready stays 1 and 20 results arrive with no gaps after the first.
